// File: rtl/vp_encoder_sched.sv
// Layer-level sequencer for the VP encoder: per chunk load -> encoder start -> run -> drain,
// forwarding each readied ping-pong buffer to the PE array through a 2-entry side queue.
module vp_encoder_sched #(
   parameter int MAX_CHUNKS = 64,
   parameter int TIMEOUT    = 1024,
   parameter int BUFCNT_W   = 8,
   localparam int CW        = $clog2(MAX_CHUNKS + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_layer_start,
   input  logic [CW-1:0]       i_num_chunks,
   output logic                o_chunk_load,
   output logic [CW-1:0]       o_chunk_idx,
   input  logic                i_chunk_loaded,
   output logic                o_enc_start,
   input  logic                i_enc_right_ready,
   input  logic                i_enc_left_ready,
   input  logic                i_enc_finish,
   output logic                o_pe_valid,
   output logic                o_pe_sel,
   input  logic                i_pe_ready,
   output logic [BUFCNT_W-1:0] o_buf_count,
   output logic                o_busy,
   output logic                o_layer_done,
   output logic                o_overrun,
   output logic                o_timeout
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_NEXT, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       num_q, num_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [BUFCNT_W-1:0] buf_cnt_q, buf_cnt_d;
   logic                overrun_q, overrun_d;
   logic                timeout_q, timeout_d;
   logic                chunk_load_q, chunk_load_d;
   logic                r_prev_q, r_prev_d;
   logic                l_prev_q, l_prev_d;
   // Queue storage: q0 is the head, q1 the tail when two entries are held.
   logic [1:0]          q_cnt_q, q_cnt_d;
   logic                q0_q, q0_d;
   logic                q1_q, q1_d;

   logic                active;
   logic [1:0]          edge_ev;
   logic                pop;
   logic                present;
   logic                sd;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      num_d        = num_q;
      wd_d         = wd_q;
      buf_cnt_d    = buf_cnt_q;
      overrun_d    = overrun_q;
      timeout_d    = timeout_q;
      q_cnt_d      = q_cnt_q;
      q0_d         = q0_q;
      q1_d         = q1_q;
      present      = 1'b0;
      sd           = 1'b0;
      r_prev_d     = i_enc_right_ready;
      l_prev_d     = i_enc_left_ready;

      active     = (state_q == S_RUN) || (state_q == S_DRAIN);
      edge_ev[0] = active && i_enc_right_ready && !r_prev_q;
      edge_ev[1] = active && i_enc_left_ready && !l_prev_q;

      // Pop first so a full queue can take a new buffer in the same cycle.
      pop = (q_cnt_q != 2'd0) && i_pe_ready;
      if (pop) begin
         q0_d    = q1_q;
         q_cnt_d = q_cnt_q - 2'd1;
      end

      // Right side (index 0) is pushed before left when both rise together.
      for (int s = 0; s < 2; s++) begin
         if (edge_ev[s]) begin
            sd      = (s != 0);
            present = ((q_cnt_d != 2'd0) && (q0_d == sd)) ||
                      ((q_cnt_d == 2'd2) && (q1_d == sd));
            if (present || (q_cnt_d == 2'd2)) begin
               overrun_d = 1'b1;
            end else begin
               if (q_cnt_d == 2'd0) q0_d = sd;
               else                 q1_d = sd;
               q_cnt_d = q_cnt_d + 2'd1;
               if (buf_cnt_d != '1) buf_cnt_d = buf_cnt_d + 1'b1;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (i_layer_start) begin
               num_d = i_num_chunks;
               if (i_num_chunks == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_LOAD;
                  overrun_d = 1'b0;
                  timeout_d = 1'b0;
                  idx_d     = '0;
               end
            end
         end
         S_LOAD: begin
            if (i_chunk_loaded) state_d = S_START;
         end
         S_START: begin
            wd_d      = '0;
            buf_cnt_d = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (i_enc_finish) begin
               state_d = S_DRAIN;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               q_cnt_d   = 2'd0;
               state_d   = S_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // Leave once the last buffer has been handed over this cycle.
            if (q_cnt_d == 2'd0) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (idx_q == num_q - CW'(1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + CW'(1);
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      chunk_load_d = (state_d == S_LOAD) && (state_q != S_LOAD);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         num_q        <= '0;
         wd_q         <= '0;
         buf_cnt_q    <= '0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
         chunk_load_q <= 1'b0;
         r_prev_q     <= 1'b0;
         l_prev_q     <= 1'b0;
         q_cnt_q      <= 2'd0;
         q0_q         <= 1'b0;
         q1_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         num_q        <= num_d;
         wd_q         <= wd_d;
         buf_cnt_q    <= buf_cnt_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
         chunk_load_q <= chunk_load_d;
         r_prev_q     <= r_prev_d;
         l_prev_q     <= l_prev_d;
         q_cnt_q      <= q_cnt_d;
         q0_q         <= q0_d;
         q1_q         <= q1_d;
      end
   end

   assign o_chunk_load = chunk_load_q;
   assign o_chunk_idx  = idx_q;
   assign o_enc_start  = (state_q == S_START);
   assign o_pe_valid   = (q_cnt_q != 2'd0);
   assign o_pe_sel     = q0_q;
   assign o_buf_count  = buf_cnt_q;
   assign o_busy       = (state_q != S_IDLE);
   assign o_layer_done = (state_q == S_DONE);
   assign o_overrun    = overrun_q;
   assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_vp_encoder_sched.sv
// Scoreboard bench for vp_encoder_sched: stimulus pushes expected buffer sides,
// a negedge monitor pops and compares on each PE handshake and checks hold-stability.
module tb_vp_encoder_sched;

   localparam int MAXC = 64;
   localparam int TO   = 16;
   localparam int BW   = 8;
   localparam int CW   = $clog2(MAXC + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          layer_start = 1'b0;
   logic [CW-1:0] num_chunks = '0;
   logic          chunk_load;
   logic [CW-1:0] chunk_idx;
   logic          chunk_loaded = 1'b0;
   logic          enc_start;
   logic          r_rdy = 1'b0;
   logic          l_rdy = 1'b0;
   logic          finish = 1'b0;
   logic          pe_valid;
   logic          pe_sel;
   logic          pe_ready = 1'b0;
   logic [BW-1:0] buf_count;
   logic          busy;
   logic          layer_done;
   logic          overrun;
   logic          timeout;

   vp_encoder_sched #(.MAX_CHUNKS(MAXC), .TIMEOUT(TO), .BUFCNT_W(BW)) dut (
      .i_clk(clk), .i_rst(rst), .i_layer_start(layer_start), .i_num_chunks(num_chunks),
      .o_chunk_load(chunk_load), .o_chunk_idx(chunk_idx), .i_chunk_loaded(chunk_loaded),
      .o_enc_start(enc_start), .i_enc_right_ready(r_rdy), .i_enc_left_ready(l_rdy),
      .i_enc_finish(finish), .o_pe_valid(pe_valid), .o_pe_sel(pe_sel), .i_pe_ready(pe_ready),
      .o_buf_count(buf_count), .o_busy(busy), .o_layer_done(layer_done),
      .o_overrun(overrun), .o_timeout(timeout)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   logic exp_q[$];
   int   n_load = 0, n_start = 0, n_done = 0;
   logic stall = 1'b0, stall_sel = 1'b0, no_hold = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Monitor: inputs change just after posedge, so the negedge view is what the next edge samples.
   always @(negedge clk) begin
      if (chunk_load) n_load++;
      if (enc_start) n_start++;
      if (layer_done) n_done++;
      if (stall && !rst && !no_hold) begin
         chk("hold_valid", int'(pe_valid), 1);
         chk("hold_sel", int'(pe_sel), int'(stall_sel));
      end
      stall     = pe_valid && !pe_ready && !rst;
      stall_sel = pe_sel;
      if (pe_valid && pe_ready && !rst) begin
         if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
         else chk("pe_sel", int'(pe_sel), int'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_layer(input int n);
      layer_start = 1'b1;
      num_chunks  = CW'(n);
      tick();
      layer_start = 1'b0;
   endtask

   // Wait for the load request, answer it, confirm the encoder start pulse, then step into run.
   task automatic enter_run(input int idx);
      int n = 0;
      while (!chunk_load && n < 20) begin tick(); n++; end
      chk("chunk_load_seen", int'(chunk_load), 1);
      chk("chunk_idx", int'(chunk_idx), idx);
      chunk_loaded = 1'b1;
      tick();
      chunk_loaded = 1'b0;
      chk("enc_start", int'(enc_start), 1);
      tick();
   endtask

   task automatic rdy_pulse(input logic side);
      if (side) l_rdy = 1'b1; else r_rdy = 1'b1;
      exp_q.push_back(side);
      tick();
      r_rdy = 1'b0;
      l_rdy = 1'b0;
   endtask

   task automatic fin();
      finish = 1'b1;
      tick();
      finish = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!layer_done && n < 20) begin tick(); n++; end
      chk("layer_done_seen", int'(layer_done), 1);
      tick();
   endtask

   initial begin
      int b_load, b_start, b_done, n;

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      chk("reset_outs", int'({chunk_load, chunk_idx, enc_start, pe_valid, pe_sel,
                              buf_count, busy, layer_done, overrun, timeout}), 0);

      // Single chunk: right, left, right, PE always ready
      b_done = n_done;
      pe_ready = 1'b1;
      start_layer(1);
      chk("busy_after_start", int'(busy), 1);
      enter_run(0);
      rdy_pulse(1'b0);
      rdy_pulse(1'b1);
      rdy_pulse(1'b0);
      fin();
      chk("single_buf_count", int'(buf_count), 3);
      wait_done();
      chk("single_done_cnt", n_done - b_done, 1);
      chk("single_idle", int'(busy), 0);

      // Backpressure over three chunks, PE ready low 2 cycles per buffer
      b_start = n_start; b_done = n_done;
      pe_ready = 1'b0;
      start_layer(3);
      for (int k = 0; k < 3; k++) begin
         enter_run(k);
         rdy_pulse(k[0]);
         repeat (2) tick();
         pe_ready = 1'b1;
         tick();
         pe_ready = 1'b0;
         fin();
      end
      wait_done();
      chk("bp_enc_starts", n_start - b_start, 3);
      chk("bp_done_cnt", n_done - b_done, 1);
      chk("bp_buf_count", int'(buf_count), 1);

      // Overrun: right re-readied before PE consumed the first
      start_layer(1);
      enter_run(0);
      rdy_pulse(1'b0);
      tick();
      r_rdy = 1'b1;
      tick();
      r_rdy = 1'b0;
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_buf_count", int'(buf_count), 1);
      chk("ovr_valid", int'(pe_valid), 1);
      chk("ovr_queue_depth", exp_q.size(), 1);
      pe_ready = 1'b1;
      tick();
      pe_ready = 1'b0;
      chk("ovr_drained", int'(pe_valid), 0);
      fin();
      wait_done();
      chk("ovr_sticky", int'(overrun), 1);
      start_layer(1);
      chk("ovr_cleared", int'(overrun), 0);
      enter_run(0);
      fin();
      wait_done();

      // Timeout: first seen after the 16th run cycle (17 ticks from the start cycle); queue flushed
      b_done = n_done;
      no_hold = 1'b1;
      start_layer(1);
      enter_run(0);
      n = 1;
      while (!timeout && n < 40) begin
         r_rdy = (n == 2);
         tick();
         n++;
      end
      r_rdy = 1'b0;
      chk("to_cycles", n, 17);
      chk("to_flag", int'(timeout), 1);
      chk("to_idle", int'(busy), 0);
      chk("to_flushed", int'(pe_valid), 0);
      tick();
      no_hold = 1'b0;
      chk("to_no_done", n_done - b_done, 0);

      // Reset in run with one buffer queued
      start_layer(1);
      chk("to_cleared", int'(timeout), 0);
      enter_run(0);
      rdy_pulse(1'b0);
      chk("rst_pre_valid", int'(pe_valid), 1);
      rst = 1'b1;
      tick();
      chk("rst_mid_outs", int'({chunk_load, chunk_idx, enc_start, pe_valid, pe_sel,
                                buf_count, busy, layer_done, overrun, timeout}), 0);
      tick();
      rst = 1'b0;
      exp_q.delete();
      tick();
      chk("rst_mid_busy", int'(busy), 0);

      // Zero chunks: done without load or encoder start
      b_load = n_load; b_start = n_start; b_done = n_done;
      start_layer(0);
      wait_done();
      chk("zero_loads", n_load - b_load, 0);
      chk("zero_starts", n_start - b_start, 0);
      chk("zero_done_cnt", n_done - b_done, 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang want finish");
      $fatal(1, "simulation timeout");
   end

endmodule
